// File: rtl/digit_serial_addsub.sv
// ============================================================================
// Module      : digit_serial_addsub
// Description : Multi-cycle signed adder/subtractor, DIGIT bits per clock,
//               WIDTH+1-bit sign-extended exact result with carry and overflow.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module digit_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH:0]   S,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   dcnt;
    logic [WIDTH:0]     s_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic [DIGIT:0]     carries;
    logic [DIGIT-1:0]   dsum;
    logic               last_digit;
    logic               accept;

    assign last_digit = (dcnt == CNT_W'(N - 1));
    assign accept     = start && ready;

    // Operands are shifted down so the current digit always sits in the low bits.
    assign carries[0] = carry;

    for (genvar j = 0; j < DIGIT; j++) begin : g_fa
        assign dsum[j]      = a_sh[j] ^ b_sh[j] ^ carries[j];
        assign carries[j+1] = (a_sh[j] & b_sh[j]) | (a_sh[j] & carries[j])
                            | (b_sh[j] & carries[j]);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            dcnt     <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= sub ? ~B : B;
            carry <= sub ? ~cin : cin;
            dcnt  <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            carry <= carries[DIGIT];
            dcnt  <= dcnt + 1'b1;
            for (int i = 0; i < N; i++) begin
                if (dcnt == CNT_W'(i)) begin
                    s_reg[i*DIGIT +: DIGIT] <= dsum;
                end
            end
            // Top digit: extend the sign through one more full-adder cell.
            if (last_digit) begin
                s_reg[WIDTH] <= a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ carries[DIGIT];
                cout_reg     <= (a_sh[DIGIT-1] & b_sh[DIGIT-1])
                              | (a_sh[DIGIT-1] & carries[DIGIT])
                              | (b_sh[DIGIT-1] & carries[DIGIT]);
                ovf_reg      <= carries[DIGIT] ^ carries[DIGIT-1];
            end
        end
    end

    assign S    = s_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

`default_nettype wire
